// File: rtl/ioctl_upload_pkg.sv
// Shared types and constants for the HPS ioctl upload path.
package ioctl_upload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/ioctl_uploader_if.sv
// HPS ioctl read port plus shared-RAM request port, bundled for the uploader.
interface ioctl_uploader_if #(
  parameter int AW = 17
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [7:0]    mem_q;

  // Uploader side: serves the HPS and masters the RAM port.
  modport master (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_gnt, mem_q,
    output ioctl_din, ioctl_wait, mem_req, mem_addr
  );

  // Environment side: HPS and RAM arbiter.
  modport slave (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_gnt, mem_q,
    input  ioctl_din, ioctl_wait, mem_req, mem_addr
  );
endinterface

// File: rtl/ioctl_uploader.sv
// Serves HPS upload reads from a shared RAM port; out-of-range reads return FILL_BYTE.
// Optional running byte checksum enabled by defining IOCTL_UPLOADER_CHECKSUM_EN.
module ioctl_uploader
  import ioctl_upload_pkg::*;
#(
  parameter int AW   = 17,
  parameter int SIZE = 131072
) (
  input  logic              clk_sys,
  input  logic              reset,
  ioctl_uploader_if.master  bus,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam logic [24:0] SIZE_L = 25'(SIZE);

  state_e        state_q;
  logic [7:0]    din_q;
  logic          wait_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic          done_q;
  logic          upload_q;
  logic          delivered_q;

  logic rise_s, fall_s, rd_ok_s, in_range_s, fill_s, capture_s, deliver_s;

  assign rise_s     = bus.ioctl_upload & ~upload_q;
  assign fall_s     = ~bus.ioctl_upload & upload_q;
  assign rd_ok_s    = (state_q == IDLE) & bus.ioctl_upload & bus.ioctl_rd;
  assign in_range_s = (bus.ioctl_addr < SIZE_L);
  assign fill_s     = rd_ok_s & ~in_range_s;
  assign capture_s  = (state_q == DATA) & bus.ioctl_upload;
  assign deliver_s  = fill_s | capture_s;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      din_q       <= 8'd0;
      wait_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      upload_q    <= 1'b0;
      delivered_q <= 1'b0;
    end else begin
      upload_q    <= bus.ioctl_upload;
      done_q      <= fall_s & delivered_q;
      delivered_q <= (rise_s ? 1'b0 : delivered_q) | deliver_s;
      case (state_q)
        IDLE: begin
          if (rd_ok_s && in_range_s) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= bus.ioctl_addr[AW-1:0];
            wait_q     <= 1'b1;
          end else if (fill_s) begin
            din_q <= FILL_BYTE;
          end
        end
        REQ: begin
          // Session close wins over a grant arriving in the same cycle.
          if (!bus.ioctl_upload) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            wait_q    <= 1'b0;
          end else if (bus.mem_gnt) begin
            state_q   <= DATA;
            mem_req_q <= 1'b0;
          end
        end
        DATA: begin
          if (!bus.ioctl_upload) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
          end else begin
            din_q   <= bus.mem_q;
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          wait_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IOCTL_UPLOADER_CHECKSUM_EN
  logic [7:0] checksum_q;
  logic [7:0] checksum_d;
  logic [7:0] deliver_byte_s;

  // Next checksum: cleared on session open, then accumulates the delivered byte.
  always_comb begin
    deliver_byte_s = capture_s ? bus.mem_q : FILL_BYTE;
    checksum_d     = rise_s ? 8'd0 : checksum_q;
    if (deliver_s) begin
      checksum_d = checksum_d + deliver_byte_s;
    end else begin
      checksum_d = checksum_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum_q <= 8'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'd0;
`endif

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ioctl_uploader.sv
// Directed self-checking bench for ioctl_uploader with a small RAM model.
module tb_ioctl_uploader;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] checksum;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  int         acc_base;
  logic [7:0] ram [256];
  logic [7:0] exp_sum;

  ioctl_uploader_if #(.AW(17)) bus();

  ioctl_uploader #(.AW(17), .SIZE(131072)) dut (
    .clk_sys  (clk),
    .reset    (rst),
    .bus      (bus.master),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // RAM model: data one cycle after a granted request.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) begin
      bus.mem_q <= ram[bus.mem_addr[7:0]];
      acc_cnt   <= acc_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_rd(input logic [24:0] a);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    step();
    bus.ioctl_rd   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[8'h10] = 8'h5A;
    ram[8'h20] = 8'h80;
    ram[8'h21] = 8'h90;
    ram[8'h22] = 8'h01;
    ram[8'h30] = 8'h3C;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 25'd0;
    bus.mem_gnt      = 1'b0;
    bus.mem_q        = 8'd0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_din",  32'(bus.ioctl_din), 32'h00);
    check("rst_wait", 32'(bus.ioctl_wait), 32'h0);
    check("rst_req",  32'(bus.mem_req), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Session 1: in-range read with immediate grant, then out-of-range fill.
    bus.ioctl_upload = 1'b1;
    bus.mem_gnt      = 1'b1;
    step();
    issue_rd(25'h10);
    check("a_wait_n1", 32'(bus.ioctl_wait), 32'h1);
    check("a_req_n1",  32'(bus.mem_req), 32'h1);
    check("a_addr_n1", 32'(bus.mem_addr), 32'h10);
    step();
    check("a_wait_n2", 32'(bus.ioctl_wait), 32'h1);
    check("a_req_n2",  32'(bus.mem_req), 32'h0);
    step();
    check("a_din_n3",  32'(bus.ioctl_din), 32'h5A);
    check("a_wait_n3", 32'(bus.ioctl_wait), 32'h0);

    issue_rd(25'h20000);
    check("c_din_n1",  32'(bus.ioctl_din), 32'hFF);
    check("c_wait_n1", 32'(bus.ioctl_wait), 32'h0);
    check("c_req_n1",  32'(bus.mem_req), 32'h0);
    step();
    check("c_wait_n2", 32'(bus.ioctl_wait), 32'h0);
    check("c_req_n2",  32'(bus.mem_req), 32'h0);
`ifdef IOCTL_UPLOADER_CHECKSUM_EN
    exp_sum = 8'h59;
`else
    exp_sum = 8'h00;
`endif
    check("s1_sum", 32'(checksum), 32'(exp_sum));
    bus.ioctl_upload = 1'b0;
    check("s1_done_pre", 32'(done), 32'h0);
    step();
    check("s1_done", 32'(done), 32'h1);
    step();
    check("s1_done_end", 32'(done), 32'h0);

    // Session 2: abort in REQ with nothing delivered.
    bus.ioctl_upload = 1'b1;
    bus.mem_gnt      = 1'b0;
    step();
    check("s2_sum_clr", 32'(checksum), 32'h00);
    issue_rd(25'h40);
    check("s2_req", 32'(bus.mem_req), 32'h1);
    bus.ioctl_upload = 1'b0;
    step();
    check("s2_abort_req",  32'(bus.mem_req), 32'h0);
    check("s2_abort_wait", 32'(bus.ioctl_wait), 32'h0);
    check("s2_abort_din",  32'(bus.ioctl_din), 32'hFF);
    step();
    check("s2_no_done", 32'(done), 32'h0);
    step();
    check("s2_no_done2", 32'(done), 32'h0);

    // Session 3: withheld grant, then checksum build 0x80+0x90+0x01.
    bus.ioctl_upload = 1'b1;
    step();
    issue_rd(25'h20);
    for (int i = 0; i < 5; i++) begin
      check("b_req_hold",  32'(bus.mem_req), 32'h1);
      check("b_addr_hold", 32'(bus.mem_addr), 32'h20);
      check("b_wait_hold", 32'(bus.ioctl_wait), 32'h1);
      step();
    end
    bus.mem_gnt = 1'b1;
    step();
    check("b_req_g1",  32'(bus.mem_req), 32'h0);
    check("b_wait_g1", 32'(bus.ioctl_wait), 32'h1);
    step();
    check("b_din_g2",  32'(bus.ioctl_din), 32'h80);
    check("b_wait_g2", 32'(bus.ioctl_wait), 32'h0);
    issue_rd(25'h21);
    step();
    step();
    check("b_din_90", 32'(bus.ioctl_din), 32'h90);
    issue_rd(25'h22);
    step();
    step();
    check("b_din_01", 32'(bus.ioctl_din), 32'h01);
`ifdef IOCTL_UPLOADER_CHECKSUM_EN
    exp_sum = 8'h11;
`else
    exp_sum = 8'h00;
`endif
    check("s3_sum", 32'(checksum), 32'(exp_sum));
    bus.ioctl_upload = 1'b0;
    step();
    check("s3_done", 32'(done), 32'h1);
    step();
    check("s3_done_end", 32'(done), 32'h0);
    bus.ioctl_upload = 1'b1;
    step();
    check("s4_sum_clr", 32'(checksum), 32'h00);

    // Second rd during REQ ignored; reset asserted in DATA.
    bus.mem_gnt = 1'b0;
    acc_base = acc_cnt;
    issue_rd(25'h30);
    issue_rd(25'h31);
    check("d_addr_keep", 32'(bus.mem_addr), 32'h30);
    check("d_wait", 32'(bus.ioctl_wait), 32'h1);
    bus.mem_gnt = 1'b1;
    step();
    check("d_in_data_req", 32'(bus.mem_req), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_din",  32'(bus.ioctl_din), 32'h00);
    check("r_wait", 32'(bus.ioctl_wait), 32'h0);
    check("r_req",  32'(bus.mem_req), 32'h0);
    check("r_addr", 32'(bus.mem_addr), 32'h0);
    check("r_done", 32'(done), 32'h0);
    check("r_sum",  32'(checksum), 32'h00);
    step();
    step();
    check("d_one_access", 32'(acc_cnt - acc_base), 32'd1);
    check("r_din_hold", 32'(bus.ioctl_din), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ioctl_uploader.md
IOCTL_UPLOADER -- requirements
Module: ioctl_uploader

Interface
REQ-001 Parameter AW, default 17: width of mem_addr.
REQ-002 Parameter SIZE, default 131072: number of bytes exposed for upload.
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_upload  in  1  high while the HPS upload session is open.
REQ-006 ioctl_rd  in  1  one-cycle read strobe from the HPS.
REQ-007 ioctl_addr  in  25  byte address, valid with ioctl_rd.
REQ-008 ioctl_din  out  8  byte returned to the HPS.
REQ-009 ioctl_wait  out  1  high while a read is outstanding; the HPS holds off.
REQ-010 mem_req  out  1  request to the shared RAM port (game side has priority).
REQ-011 mem_addr  out  AW  RAM address, stable while mem_req is high.
REQ-012 mem_gnt  in  1  grant; a read is taken in any cycle with mem_req and mem_gnt both high.
REQ-013 mem_q  in  8  RAM data, valid one cycle after the grant cycle.
REQ-014 done  out  1  one-cycle pulse at the end of a session.
REQ-015 checksum  out  8  running byte sum of the session.

Function
REQ-016 FSM states: IDLE, REQ, DATA; held in one registered state variable.
REQ-017 IDLE + ioctl_upload + ioctl_rd (cycle N) with ioctl_addr < SIZE -> REQ; from N+1, mem_req=1, mem_addr=ioctl_addr[AW-1:0], ioctl_wait=1.
REQ-018 REQ with mem_gnt=1 (cycle G) -> DATA; mem_req=0 from G+1.
REQ-019 DATA (cycle G+1): capture mem_q into ioctl_din; from G+2, ioctl_wait=0 and state=IDLE. Minimum latency is ioctl_rd to data = 3 cycles.
REQ-020 ioctl_addr >= SIZE: no RAM access; ioctl_din=8'hFF from N+1; ioctl_wait stays 0.
REQ-021 ioctl_din holds its last value until the next completed read.
REQ-022 ioctl_rd while state != IDLE is ignored; the outstanding read completes unchanged.
REQ-023 ioctl_upload falling while in REQ or DATA: abort to IDLE next cycle; mem_req=0, ioctl_wait=0; ioctl_din unchanged.
REQ-024 Rising edge of ioctl_upload clears checksum and the delivered-byte flag.
REQ-025 done pulses for exactly one cycle, the cycle after ioctl_upload falls, only if at least one byte was delivered in the session.
REQ-026 mem_gnt is ignored outside REQ.

Reset
REQ-027 On reset: state=IDLE, ioctl_din=0, ioctl_wait=0, mem_req=0, mem_addr=0, done=0, checksum=0. Applies in any state, including mid-read.

Configuration
REQ-028 Macro IOCTL_UPLOADER_CHECKSUM_EN defined: every delivered byte, including 8'hFF fills, is added modulo 256 into checksum in the cycle ioctl_din updates.
REQ-029 Macro not defined: checksum tied to 0; no adder synthesised; all other behaviour identical.

Structure
REQ-030 Shared package ioctl_upload_pkg holds the state enum and the constant FILL_BYTE=8'hFF.
REQ-031 Single flat module; no sub-module is warranted.

Verification
REQ-032 Upload high, rd addr 0x10, gnt immediate, RAM[0x10]=0x5A -> wait high N+1..N+2, din=0x5A and wait=0 at N+3.
REQ-033 Grant withheld 5 cycles -> mem_req and mem_addr stable throughout; din valid 2 cycles after grant; wait high until then.
REQ-034 rd addr=SIZE -> din=0xFF at N+1, mem_req never high, wait never high.
REQ-035 ioctl_upload drops in REQ -> next cycle IDLE, mem_req=0, wait=0; no done pulse if no byte was delivered.
REQ-036 Checksum build: bytes 0x80, 0x90, 0x01 delivered, then upload falls -> checksum=0x11, done pulses once; a new session clears checksum to 0.
REQ-037 reset asserted in DATA -> all outputs at reset values next cycle; a second rd issued during REQ produces no extra RAM access.
